// File: rtl/acorn_prng_v2_if.sv
// ---------------------------------------------------------------------------
// acorn_prng_v2_if
//
// Purpose:
//   Bundles the seed-selection inputs and the output valid/ready handshake of
//   the ACORN generator, so a wrapper or testbench can pass them as one port.
//
// Signals (WIDTH = word width):
//   load       master->slave  capture a seed and restart the generator
//   select     master->slave  seed source: 00 gpio, 01 LA, 10 constant, 11 out
//   gpio_seed  master->slave  seed from pads
//   la_seed    master->slave  seed from logic-analyzer probes
//   free_run   master->slave  advance every RUN cycle regardless of out_ready
//   out_ready  master->slave  consumer accepts the current word
//   out        slave->master  current random word
//   out_valid  slave->master  out holds a valid word
//   reset_out  slave->master  generator unseeded or still warming up
//   overrun    slave->master  sticky: a valid word was dropped in free_run
//
// Modports:
//   master  the consumer / seed provider
//   slave   the generator
// ---------------------------------------------------------------------------
interface acorn_prng_v2_if #(
    parameter int WIDTH = 12
);
    logic             load;
    logic [1:0]       select;
    logic [WIDTH-1:0] gpio_seed;
    logic [WIDTH-1:0] la_seed;
    logic             free_run;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             reset_out;
    logic             overrun;

    modport master (
        output load,
        output select,
        output gpio_seed,
        output la_seed,
        output free_run,
        output out_ready,
        input  out,
        input  out_valid,
        input  reset_out,
        input  overrun
    );

    modport slave (
        input  load,
        input  select,
        input  gpio_seed,
        input  la_seed,
        input  free_run,
        input  out_ready,
        output out,
        output out_valid,
        output reset_out,
        output overrun
    );
endinterface

// File: rtl/acorn_prng_v2.sv
// ---------------------------------------------------------------------------
// acorn_prng_v2
//
// Purpose:
//   Order-ORDER ACORN (Additive Congruential Random Number) generator working
//   modulo 2^WIDTH.  A seed Y0 is captured from one of four sources (always
//   forced odd), the accumulators Y1..Yk are cleared, WARMUP advances are
//   discarded, and the words of Yk are then offered on a valid/ready
//   handshake.  In free-run mode the generator advances every RUN cycle and
//   flags (sticky) any word that was replaced without being accepted.
//
// Parameters:
//   WIDTH         word width, all arithmetic wraps modulo 2^WIDTH
//   ORDER         number of accumulator registers Y1..Yk (k >= 1)
//   WARMUP        advances discarded after each load (0 allowed)
//   DEFAULT_SEED  constant seed source (select = 10)
//
// Ports:
//   wb_clk_i   in   single clock
//   wb_rst_i   in   synchronous, active-high reset
//   bus        slave side of acorn_prng_v2_if (seed inputs, handshake,
//              out / out_valid / reset_out / overrun, all registered)
// ---------------------------------------------------------------------------
module acorn_prng_v2 #(
    parameter int               WIDTH        = 12,
    parameter int               ORDER        = 8,
    parameter int               WARMUP       = 16,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(12'h5A5)
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    acorn_prng_v2_if.slave bus
);

    // Warm-up counter needs to hold 0..WARMUP; keep at least one bit so the
    // WARMUP = 0 build still has a legal (unused) counter.
    localparam int CNT_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    localparam logic [CNT_W-1:0] LAST_WARM = CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [CNT_W-1:0] r_cnt;

    // r_y[0] is the seed, r_y[1..ORDER] are the accumulators.
    logic [WIDTH-1:0] r_y   [0:ORDER];
    logic [WIDTH-1:0] w_new [1:ORDER];

    logic [WIDTH-1:0] w_seed_src;
    logic [WIDTH-1:0] w_seed;
    logic             w_advance;

    logic             r_out_valid;
    logic             r_reset_out;
    logic             r_overrun;
    logic             w_out_valid_next;
    logic             w_reset_out_next;
    logic             w_overrun_next;

    // -----------------------------------------------------------------------
    // Additive cascade: each accumulator takes the running sum of the seed
    // and all lower-order accumulators, so the whole order-k update settles
    // in one cycle.  The running sum lives in a block-local variable so the
    // array is never read back while it is being built.
    // -----------------------------------------------------------------------
    always_comb begin : cascade
        logic [WIDTH-1:0] w_sum;
        w_sum = r_y[0];
        for (int m = 1; m <= ORDER; m++) begin
            w_sum    = w_sum + r_y[m];
            w_new[m] = w_sum;
        end
    end

    // -----------------------------------------------------------------------
    // Seed source selection.  Source 11 feeds back the word currently shown
    // on out, which is register Yk as it stands on the load edge.  The low
    // bit is forced so the additive sequence never collapses to all zeros.
    // -----------------------------------------------------------------------
    always_comb begin
        case (bus.select)
            2'b00:   w_seed_src = bus.gpio_seed;
            2'b01:   w_seed_src = bus.la_seed;
            2'b10:   w_seed_src = DEFAULT_SEED;
            default: w_seed_src = r_y[ORDER];
        endcase
        w_seed = w_seed_src | WIDTH'(1);
    end

    // -----------------------------------------------------------------------
    // Advance decision.  A load always wins and suppresses the advance on
    // its edge (the accumulators are being cleared instead).  In RUN the
    // generator moves on either a completed handshake or free-run.
    // -----------------------------------------------------------------------
    always_comb begin
        w_advance = 1'b0;
        if (!bus.load) begin
            case (r_state)
                S_WARMUP: w_advance = 1'b1;
                S_RUN:    w_advance = bus.free_run | (r_out_valid & bus.out_ready);
                default:  w_advance = 1'b0;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic.  Load restarts from any state; with no warm-up the
    // fresh seed is presented straight away.  WARMUP leaves on the edge that
    // performs its WARMUP-th advance, i.e. when the counter shows WARMUP-1.
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (bus.load) begin
            w_next_state = (WARMUP == 0) ? S_RUN : S_WARMUP;
        end else begin
            case (r_state)
                S_IDLE:   w_next_state = S_IDLE;
                S_WARMUP: if (r_cnt == LAST_WARM) w_next_state = S_RUN;
                S_RUN:    w_next_state = S_RUN;
                default:  w_next_state = S_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output logic, computed from the upcoming state so the registered flags
    // line up with the state they describe.  Overrun latches whenever a
    // word is replaced in RUN without the consumer having taken it.
    // -----------------------------------------------------------------------
    always_comb begin
        w_out_valid_next = (w_next_state == S_RUN);
        w_reset_out_next = (w_next_state != S_RUN);
        w_overrun_next   = r_overrun |
                           ((r_state == S_RUN) & w_advance & bus.free_run & ~bus.out_ready);
    end

    // -----------------------------------------------------------------------
    // State register, warm-up counter and registered status outputs.  Reset
    // overrides load.
    // -----------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_reset_out <= 1'b1;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_out_valid <= w_out_valid_next;
            r_reset_out <= w_reset_out_next;
            r_overrun   <= w_overrun_next;
            if (bus.load) begin
                r_cnt <= '0;
            end else if ((r_state == S_WARMUP) && w_advance) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Generator registers.  Load captures the seed and clears Y1..Yk; an
    // advance writes every accumulator from the cascade on the same edge.
    // Y0 is constant between loads.
    // -----------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int m = 0; m <= ORDER; m++) begin
                r_y[m] <= '0;
            end
        end else if (bus.load) begin
            r_y[0] <= w_seed;
            for (int m = 1; m <= ORDER; m++) begin
                r_y[m] <= '0;
            end
        end else if (w_advance) begin
            for (int m = 1; m <= ORDER; m++) begin
                r_y[m] <= w_new[m];
            end
        end
    end

    assign bus.out       = r_y[ORDER];
    assign bus.out_valid = r_out_valid;
    assign bus.reset_out = r_reset_out;
    assign bus.overrun   = r_overrun;

endmodule

// File: doc/acorn_prng_v2.md
# acorn_prng_v2

Parametrised second-generation ACORN (Additive Congruential Random Number) generator for the Caravel user project area. It computes an order-`ORDER` ACORN sequence modulo 2^`WIDTH`, seeded from GPIO pins, logic-analyzer probes, a build-time constant, or its own last output. Output words leave through a valid/ready handshake, with an optional free-running mode. It sits behind the user-project wrapper, with pins on `mprj_io` and LA probes.

## Interface
- `WIDTH`, 12: word width; all arithmetic is mod 2^WIDTH.
- `ORDER`, 8: ACORN order k ≥ 1; number of accumulator registers Y1..Yk.
- `WARMUP`, 16: advances discarded after a load before the first valid word; 0 is legal.
- `DEFAULT_SEED`, 12'h5A5: constant seed source; resized to WIDTH.
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: reset, synchronous and active-high.
- `load` in 1: when high on an edge, capture a seed and restart the generator.
- `select` in 2: seed source. 00 = `gpio_seed`, 01 = `la_seed`, 10 = `DEFAULT_SEED`, 11 = current `out`.
- `gpio_seed` in WIDTH: seed from pads.
- `la_seed` in WIDTH: seed from LA probes.
- `free_run` in 1: 1 = advance every RUN cycle and ignore `out_ready`.
- `out_ready` in 1: consumer accepts `out`.
- `out` out WIDTH: current word, equal to register Yk.
- `out_valid` out 1: `out` holds a valid random word.
- `reset_out` out 1: high while the generator is unseeded or warming up (IDLE or WARMUP).
- `overrun` out 1: sticky flag, set when a valid word is replaced in free_run while `out_ready`=0.

## Operation
- **State:** Y0 (seed) plus Y1..Yk, each WIDTH bits. Warm-up counter is ceil(log2(WARMUP+1)) bits, minimum 1.
- **Advance:** new[0] = Y0; new[m] = (new[m-1] + Y[m]) mod 2^WIDTH for m = 1..k. This is a chained, combinational, single-cycle cascade. All Ym are written from new[m] on the same edge.
- **Seed capture:** Y0 ← (selected source) | 1, so the seed is always odd. Y1..Yk ← 0. For select=11 the seed is `out` as sampled on the load edge.
- **FSM:**
  - IDLE: entered on reset. `out_valid`=0, `reset_out`=1. No advances occur. Only `load` leaves this state.
  - WARMUP: advance every cycle and increment the counter. After the WARMUP-th advance, go to RUN. If WARMUP=0, `load` goes directly to RUN.
  - RUN: `out_valid`=1, `reset_out`=0.
    - Advance when `out_valid & out_ready`, or when `free_run`=1.
    - No advance when `free_run`=0 and `out_ready`=0; `out` holds stable.
- **load:** takes priority in every state and restarts the generator. Capture the seed, clear the counter, enter WARMUP (or RUN if WARMUP=0).
- **load with a handshake in the same RUN cycle:** the word presented that cycle counts as consumed. Load still takes effect.
- **overrun:** set on a RUN cycle with `free_run`=1, `out_ready`=0 and an advance. Cleared only by reset.
- **Wrap-around:** natural modulo truncation. No saturation, and no carry is exported.

## Timing
- **Reset values:** `out`=0, `out_valid`=0, `reset_out`=1, `overrun`=0, Y0..Yk=0, FSM=IDLE.
- **Load latency:** load sampled at edge E0. Edges E1..E_WARMUP each perform one advance. `out_valid` is 1 immediately after edge E_WARMUP (after E0 when WARMUP=0).
- **First valid word:** equals Yk after WARMUP advances. With WARMUP=0 the first word is 0, because Yk was cleared.
- **Handshake:** a word transfers on an edge where `out_valid & out_ready`. The next word is visible after that edge. Throughput is one word per cycle.
- **Outputs:** `out`, `out_valid`, `reset_out` and `overrun` are all registered. There is no combinational path from inputs to outputs.
- **Reset:** `wb_rst_i` mid-operation returns the block to IDLE on the next edge and overrides `load`.

## Test plan
- **Reset:** hold `wb_rst_i` 3 cycles with `load`=1 → IDLE, `out_valid`=0, `reset_out`=1, `out`=0, `overrun`=0. No load is taken.
- **ORDER=2, WARMUP=0, select=00, gpio_seed=0x001, out_ready=1:**
  - `out_valid` is 1 one edge after load.
  - `out` sequence: 0x000, 0x001, 0x003, 0x006, 0x00A, 0x00F.
- **Same configuration with gpio_seed=0x000:**
  - Seed forced to 1, so the sequence is identical to the previous scenario.
  - Then `out_ready`=0 for 5 cycles: `out` holds 0x006 and `out_valid` stays 1.
- **Defaults (ORDER=8, WARMUP=16), select=10:**
  - `reset_out`=1 for 16 cycles after load; `out_valid` rises after edge E16.
  - First word matches a C reference model. Then load with select=11 reseeds from the current `out`|1 and the sequence matches the model again.
- **free_run=1, out_ready=0 in RUN:**
  - `out` changes every cycle; `overrun` rises after the first advance and stays set.
  - Dropping `free_run` freezes `out`.
- **Mid-run reload and wrap:**
  - In RUN at word 5 with `out_ready`=1, assert load with select=01, la_seed=0xFFF.
  - Required: `out_valid` falls after that edge, and the warm-up restarts for the full WARMUP count.
  - With ORDER=1: `out` steps by 0xFFF per advance and wraps mod 4096 (0xFFF, 0xFFE, 0xFFD).
